bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
Sequencing controller for a four-digit cascaded BCD time counter in MM:SS format. It generates the count tick from a clock prescaler and runs an IDLE/RUN/PAUSE state machine driven by start/stop, lap and clear pulses. It gates the carry chain across digits: sec ones 0-9, sec tens 0-5, min ones 0-9, min tens 0-5. It drives a display bus that shows either the live count or a frozen lap snapshot, and feeds the board's 7-segment display mux.

Parameters:
TICK_DIV, 100000, clk cycles per one-second count tick (legal range >= 2)
PRE_W, 17, prescaler width; must satisfy 2**PRE_W >= TICK_DIV

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
start_stop  input  1  single-cycle pulse; toggles run/pause, starts from idle
lap  input  1  single-cycle pulse; toggles lap hold
clear  input  1  single-cycle pulse; returns to idle and zeroes count (PAUSE only)
sec_ones  output  4  displayed seconds units, BCD 0-9
sec_tens  output  4  displayed seconds tens, BCD 0-5
min_ones  output  4  displayed minutes units, BCD 0-9
min_tens  output  4  displayed minutes tens, BCD 0-5
running  output  1  high in RUN
paused  output  1  high in PAUSE
lap_hold  output  1  high while the display shows the frozen snapshot
wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; prescaler=0; live digits=0; snapshot=0; lap_hold=0; wrap=0.
  - All outputs read 0 the cycle after reset. Reset overrides any input pulse in the same cycle.
- States and transitions (evaluated per posedge; inputs are pulses, no edge detection inside):
  - IDLE: start_stop -> RUN. lap and clear are ignored. Live count holds at 0.
  - RUN: start_stop -> PAUSE. lap toggles lap_hold. clear is ignored.
  - PAUSE: clear -> IDLE (live digits=0, prescaler=0, lap_hold=0). Otherwise start_stop -> RUN. lap with lap_hold=1 clears lap_hold; lap with lap_hold=0 is ignored.
- Simultaneous pulses:
  - Priority is clear > start_stop > lap; only the highest-priority pulse that is valid in the current state acts.
  - Exception: in RUN, start_stop and lap together both act (-> PAUSE, lap_hold toggled).
- running and paused are decoded from the registered state and change the cycle after the accepting edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and holds its value in PAUSE, so resume continues mid-interval.
  - It is zeroed in IDLE.
  - tick = (state==RUN && prescaler==TICK_DIV-1). On tick the prescaler returns to 0.
- Digit cascade (all on the tick edge, same clock):
  - sec_ones increments; 9 -> 0 with carry.
  - On carry, sec_tens increments; 5 -> 0 with carry.
  - On carry, min_ones increments; 9 -> 0 with carry.
  - On carry, min_tens increments; 5 -> 0.
  - At 59:59 a tick gives 00:00 and sets wrap=1 for exactly that one cycle.
- Timing:
  - First increment occurs TICK_DIV posedges after the edge that entered RUN.
  - If start_stop arrives on the same edge as a tick, the tick is applied and then the block pauses, with prescaler=0.
- Lap:
  - Setting lap_hold copies the live digits into the snapshot on the same edge. If a tick coincides, the snapshot takes the pre-increment value.
  - Outputs = snapshot while lap_hold=1, otherwise live digits, through a registered-free mux.
  - Counting continues underneath the hold.
- Digit values outside BCD range are unreachable. No illegal-code recovery is required beyond reset.

Test Plan:
- TICK_DIV=4. Reset, one start_stop pulse -> running=1 next cycle; sec_ones=1 after 4 further edges, 2 after 8.
- Run to 00:09 then one tick -> 00:10. At 00:59 -> 01:00. At 09:59 -> 10:00. At 59:59 -> 00:00 with wrap high exactly 1 cycle.
- Pause 2 cycles into an interval, hold 20 cycles, resume -> next increment exactly 2 cycles after resume edge; count unchanged during PAUSE.
- At live 00:03, lap -> display frozen at 00:03, lap_hold=1. After 8 edges live is 00:05 while display still shows 00:03. Second lap -> display shows 00:05.
- clear in RUN -> ignored. Pause then clear with start_stop in same cycle -> IDLE, all digits 0, lap_hold=0, running=0.
- Assert rst mid-RUN at 12:34 with lap_hold=1 and a lap pulse coincident -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: control pulses and MM:SS display bus of the stopwatch controller
interface bcd_stopwatch_ctrl_if;
  logic start_stop, lap, clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic running, paused, lap_hold, wrap;
  modport master(output start_stop, lap, clear,
                 input sec_ones, sec_tens, min_ones, min_tens, running, paused, lap_hold, wrap);
  modport slave(input start_stop, lap, clear,
                output sec_ones, sec_tens, min_ones, min_tens, running, paused, lap_hold, wrap);
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: IDLE/RUN/PAUSE sequencer with prescaled tick, MM:SS BCD cascade and lap snapshot
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int PRE_W = 17
) (
  input logic clk,
  input logic rst,
  bcd_stopwatch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [3:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9};
  state_t state;
  logic [PRE_W-1:0] pre;
  logic [3:0][3:0] d, s, shown;
  logic [4:0] c;
  logic tick, lh, wrap;
  assign tick = state == RUN && pre == PRE_W'(TICK_DIV - 1);
  // c[i] is the carry into digit i; c[4] marks the 59:59 rollover
  always_comb begin
    c = '0;
    c[0] = tick;
    for (int i = 0; i < 4; i++) c[i+1] = c[i] && d[i] == LIM[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      d <= '0;
      s <= '0;
      lh <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= c[4];
      if (state == RUN) pre <= tick ? '0 : pre + 1'b1;
      for (int i = 0; i < 4; i++) if (c[i]) d[i] <= d[i] == LIM[i] ? 4'd0 : d[i] + 4'd1;
      case (state)
        IDLE: if (bus.start_stop) state <= RUN;
        RUN: begin
          if (bus.start_stop) state <= PAUSE;
          if (bus.lap) begin
            lh <= ~lh;
            if (!lh) s <= d;
          end
        end
        PAUSE: begin
          if (bus.clear) begin
            state <= IDLE;
            pre <= '0;
            d <= '0;
            lh <= 1'b0;
          end else if (bus.start_stop) state <= RUN;
          else if (bus.lap) lh <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign shown = lh ? s : d;
  assign bus.sec_ones = shown[0];
  assign bus.sec_tens = shown[1];
  assign bus.min_ones = shown[2];
  assign bus.min_tens = shown[3];
  assign bus.running = state == RUN;
  assign bus.paused = state == PAUSE;
  assign bus.lap_hold = lh;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: directed vectors with hand-computed MM:SS and flag expectations, TICK_DIV=4
module tb_bcd_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int nvec = 0, nerr = 0;
  logic [15:0] disp;
  logic [3:0] flg;
  bcd_stopwatch_ctrl_if bus();
  bcd_stopwatch_ctrl #(.TICK_DIV(4), .PRE_W(3)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign disp = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  assign flg = {bus.running, bus.paused, bus.lap_hold, bus.wrap};
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic ss, input logic l, input logic c);
    bus.start_stop = ss;
    bus.lap = l;
    bus.clear = c;
    @(posedge clk);
    #1;
    bus.start_stop = 1'b0;
    bus.lap = 1'b0;
    bus.clear = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask
  task automatic ticks(input int n);
    idle(4 * n);
  endtask
  initial begin
    rst = 1'b1;
    bus.start_stop = 1'b1;
    bus.lap = 1'b1;
    bus.clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start_stop = 1'b0;
    bus.lap = 1'b0;
    bus.clear = 1'b0;
    chk("rst_disp", disp, 16'h0000);
    chk("rst_flags", {12'd0, flg}, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_run", {12'd0, flg}, 16'h0008);
    idle(3);
    chk("pre_first", disp, 16'h0000);
    idle(1);
    chk("first_inc", disp, 16'h0001);
    ticks(1);
    chk("second_inc", disp, 16'h0002);
    ticks(7);
    chk("at_0009", disp, 16'h0009);
    ticks(1);
    chk("to_0010", disp, 16'h0010);
    ticks(49);
    chk("at_0059", disp, 16'h0059);
    ticks(1);
    chk("to_0100", disp, 16'h0100);
    ticks(539);
    chk("at_0959", disp, 16'h0959);
    ticks(1);
    chk("to_1000", disp, 16'h1000);
    ticks(2999);
    chk("at_5959", disp, 16'h5959);
    chk("wrap_pre", {12'd0, flg}, 16'h0008);
    idle(3);
    chk("wrap_before", {15'd0, bus.wrap}, 16'h0000);
    idle(1);
    chk("to_0000", disp, 16'h0000);
    chk("wrap_pulse", {15'd0, bus.wrap}, 16'h0001);
    idle(1);
    chk("wrap_gone", {15'd0, bus.wrap}, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0);
    chk("paused", {12'd0, flg}, 16'h0004);
    idle(20);
    chk("pause_hold", disp, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0);
    chk("resume", {12'd0, flg}, 16'h0008);
    idle(1);
    chk("resume_mid", disp, 16'h0000);
    idle(1);
    chk("resume_inc", disp, 16'h0001);
    ticks(2);
    chk("at_0003", disp, 16'h0003);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_set", {12'd0, flg}, 16'h000A);
    chk("lap_disp", disp, 16'h0003);
    idle(7);
    chk("lap_frozen", disp, 16'h0003);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_release", disp, 16'h0005);
    chk("lap_off", {12'd0, flg}, 16'h0008);
    cyc(1'b0, 1'b0, 1'b1);
    chk("clear_in_run", {12'd0, flg}, 16'h0008);
    chk("clear_in_run_d", disp, 16'h0005);
    cyc(1'b1, 1'b1, 1'b0);
    chk("ss_lap_run", {12'd0, flg}, 16'h0006);
    cyc(1'b0, 1'b1, 1'b0);
    chk("pause_lap_clr", {12'd0, flg}, 16'h0004);
    cyc(1'b0, 1'b1, 1'b0);
    chk("pause_lap_ign", {12'd0, flg}, 16'h0004);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clear_ss", {12'd0, flg}, 16'h0000);
    chk("clear_disp", disp, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0);
    chk("idle_lap", {12'd0, flg}, 16'h0000);
    idle(5);
    chk("idle_hold", disp, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tick_pause_d", disp, 16'h0001);
    chk("tick_pause_f", {12'd0, flg}, 16'h0004);
    cyc(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("pre_zeroed", disp, 16'h0001);
    idle(1);
    chk("pre_zero_inc", disp, 16'h0002);
    ticks(752);
    chk("at_1234", disp, 16'h1234);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_1234", {12'd0, flg}, 16'h000A);
    rst = 1'b1;
    bus.lap = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.lap = 1'b0;
    chk("mid_rst_disp", disp, 16'h0000);
    chk("mid_rst_flags", {12'd0, flg}, 16'h0000);
    idle(5);
    chk("post_rst_idle", disp, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
